// File: rtl/parking_report_tx_pkg.sv
// Shared constants for the parking report transmitter: ASCII bytes, line-state
// encoding and the snapshot field layout {state, best, door, full} (state in the MSBs).
package parking_report_tx_pkg;

  localparam int NUM_SLOTS_DEF  = 4;
  localparam int SLOT_IDX_W_DEF = 2;
  localparam int CHAR_IDX_W     = 3;

  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_LBR   = 8'h5b;
  localparam logic [7:0] ASC_RBR   = 8'h5d;
  localparam logic [7:0] ASC_COMMA = 8'h2c;
  localparam logic [7:0] ASC_LF    = 8'h0a;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  typedef enum logic [3:0] {
    LS_IDLE,
    LS_BITS,
    LS_SP,
    LS_LBR,
    LS_FREE,
    LS_COMMA,
    LS_BEST,
    LS_RBR,
    LS_DOOR,
    LS_FULL,
    LS_EOL
  } line_state_t;

  // Snapshot vector width for a given slot count and best-slot width.
  function automatic int snap_width(input int num_slots, input int slot_idx_w);
    return num_slots + slot_idx_w + 2;
  endfunction

  // " door"
  function automatic logic [7:0] door_char(input logic [CHAR_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return ASC_SP;
      3'd1:    return 8'h64;
      3'd2:    return 8'h6f;
      3'd3:    return 8'h6f;
      3'd4:    return 8'h72;
      default: return ASC_SP;
    endcase
  endfunction

  // " Full"
  function automatic logic [7:0] full_char(input logic [CHAR_IDX_W-1:0] idx);
    case (idx)
      3'd0:    return ASC_SP;
      3'd1:    return 8'h46;
      3'd2:    return 8'h75;
      3'd3:    return 8'h6c;
      3'd4:    return 8'h6c;
      default: return ASC_SP;
    endcase
  endfunction

endpackage

// File: rtl/parking_report_tx_if.sv
// Sample strobe plus ASCII byte stream between the parking FSM side and the report sink.
// Byte stream: tx_data/tx_valid stay stable while tx_valid && !tx_ready; a byte moves on
// the rising edge where tx_valid && tx_ready; tx_ready may change freely at any time.
interface parking_report_tx_if #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_IDX_W = 2
);
  logic                  sample_valid;
  logic [NUM_SLOTS-1:0]  current_state;
  logic [SLOT_IDX_W-1:0] best_slot;
  logic                  door_open;
  logic                  full_light;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output sample_valid, current_state, best_slot, door_open, full_light, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  sample_valid, current_state, best_slot, door_open, full_light, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/parking_report_tx_char_sel.sv
// Combinational byte selector: maps the current line position and the active
// snapshot onto the ASCII byte presented on the stream.
module parking_report_tx_char_sel
  import parking_report_tx_pkg::*;
#(
  parameter int NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int SLOT_IDX_W = SLOT_IDX_W_DEF
) (
  input  line_state_t           i_state,
  input  logic [CHAR_IDX_W-1:0] i_idx,
  input  logic [NUM_SLOTS-1:0]  i_bitmap,
  input  logic [SLOT_IDX_W-1:0] i_best,
  output logic [7:0]            o_byte
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] w_free;
  logic             w_bit;

  always_comb begin
    w_pop = '0;
    w_bit = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_pop = w_pop + CNT_W'(i_bitmap[k]);
      // bitmap is printed MSB first, so char index 0 selects bit NUM_SLOTS-1
      if (i_idx == CHAR_IDX_W'(NUM_SLOTS - 1 - k)) w_bit = i_bitmap[k];
    end
    w_free = CNT_W'(NUM_SLOTS) - w_pop;
  end

  always_comb begin
    o_byte = 8'h00;
    case (i_state)
      LS_IDLE:  o_byte = 8'h00;
      LS_BITS:  o_byte = ASC_ZERO + {7'd0, w_bit};
      LS_SP:    o_byte = ASC_SP;
      LS_LBR:   o_byte = ASC_LBR;
      LS_FREE:  o_byte = ASC_ZERO + 8'(w_free);
      LS_COMMA: o_byte = ASC_COMMA;
      LS_BEST:  o_byte = ASC_ZERO + 8'(i_best);
      LS_RBR:   o_byte = ASC_RBR;
      LS_DOOR:  o_byte = door_char(i_idx);
      LS_FULL:  o_byte = full_char(i_idx);
      LS_EOL:   o_byte = ASC_LF;
      default:  o_byte = 8'h00;
    endcase
  end
endmodule

// File: rtl/parking_report_tx.sv
// Parking status reporter: snapshots the FSM outputs on each strobe and streams one
// ASCII report line per snapshot, with a 1-deep newest-wins pending slot.
module parking_report_tx
  import parking_report_tx_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int SLOT_IDX_W  = SLOT_IDX_W_DEF,
  parameter bit CHANGE_ONLY = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  parking_report_tx_if.slave  bus,
  output logic                o_busy,
  output logic                o_dropped,
  output line_state_t         o_dbg_state
);
  localparam int SNAP_W = snap_width(NUM_SLOTS, SLOT_IDX_W);

  line_state_t           r_state,      w_state_nxt;
  logic [CHAR_IDX_W-1:0] r_idx,        w_idx_nxt;
  logic [SNAP_W-1:0]     r_active,     w_active_nxt;
  logic [SNAP_W-1:0]     r_pending,    w_pending_nxt;
  logic                  r_pend_valid, w_pend_valid_nxt;
  logic [SNAP_W-1:0]     r_last,       w_last_nxt;
  logic                  r_last_valid, w_last_valid_nxt;
  logic                  r_dropped,    w_dropped_nxt;

  logic [SNAP_W-1:0] w_sample;
  logic              w_take;
  logic              w_accept;
  logic              w_act_door;
  logic              w_act_full;
  logic [7:0]        w_byte;

  assign w_sample   = {bus.current_state, bus.best_slot, bus.door_open, bus.full_light};
  // With CHANGE_ONLY a strobe repeating the newest captured snapshot is not a capture at all
  assign w_take     = bus.sample_valid &&
                      !(CHANGE_ONLY && r_last_valid && (w_sample == r_last));
  assign w_accept   = (r_state != LS_IDLE) && bus.tx_ready;
  assign w_act_door = r_active[1];
  assign w_act_full = r_active[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= LS_IDLE;
      r_idx        <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_last       <= '0;
      r_last_valid <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_active     <= w_active_nxt;
      r_pending    <= w_pending_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_last       <= w_last_nxt;
      r_last_valid <= w_last_valid_nxt;
      r_dropped    <= w_dropped_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_active_nxt     = r_active;
    w_pending_nxt    = r_pending;
    w_pend_valid_nxt = r_pend_valid;
    w_last_nxt       = r_last;
    w_last_valid_nxt = r_last_valid;
    w_dropped_nxt    = 1'b0;

    if (w_take) begin
      w_last_nxt       = w_sample;
      w_last_valid_nxt = 1'b1;
    end

    case (r_state)
      LS_IDLE: begin
        if (w_take) begin
          w_state_nxt  = LS_BITS;
          w_idx_nxt    = '0;
          w_active_nxt = w_sample;
        end
      end

      LS_EOL: begin
        if (w_accept) begin
          // Line ends: pending (if any) is promoted and a same-cycle sample backfills it
          if (r_pend_valid) begin
            w_state_nxt      = LS_BITS;
            w_idx_nxt        = '0;
            w_active_nxt     = r_pending;
            w_pend_valid_nxt = w_take;
            if (w_take) w_pending_nxt = w_sample;
          end else if (w_take) begin
            w_state_nxt  = LS_BITS;
            w_idx_nxt    = '0;
            w_active_nxt = w_sample;
          end else begin
            w_state_nxt = LS_IDLE;
          end
        end else if (w_take) begin
          w_pending_nxt    = w_sample;
          w_pend_valid_nxt = 1'b1;
          w_dropped_nxt    = r_pend_valid;
        end
      end

      default: begin
        if (w_take) begin
          w_pending_nxt    = w_sample;
          w_pend_valid_nxt = 1'b1;
          w_dropped_nxt    = r_pend_valid;
        end
        if (w_accept) begin
          case (r_state)
            LS_BITS: begin
              if (r_idx == CHAR_IDX_W'(NUM_SLOTS - 1)) begin
                w_state_nxt = LS_SP;
                w_idx_nxt   = '0;
              end else begin
                w_idx_nxt = r_idx + 1'b1;
              end
            end
            LS_SP:    w_state_nxt = LS_LBR;
            LS_LBR:   w_state_nxt = LS_FREE;
            LS_FREE:  w_state_nxt = LS_COMMA;
            LS_COMMA: w_state_nxt = LS_BEST;
            LS_BEST:  w_state_nxt = LS_RBR;
            LS_RBR: begin
              w_idx_nxt = '0;
              if (w_act_door)      w_state_nxt = LS_DOOR;
              else if (w_act_full) w_state_nxt = LS_FULL;
              else                 w_state_nxt = LS_EOL;
            end
            LS_DOOR: begin
              if (r_idx == 3'd4) begin
                w_idx_nxt   = '0;
                w_state_nxt = w_act_full ? LS_FULL : LS_EOL;
              end else begin
                w_idx_nxt = r_idx + 1'b1;
              end
            end
            LS_FULL: begin
              if (r_idx == 3'd4) begin
                w_idx_nxt   = '0;
                w_state_nxt = LS_EOL;
              end else begin
                w_idx_nxt = r_idx + 1'b1;
              end
            end
            default: w_state_nxt = LS_IDLE;
          endcase
        end
      end
    endcase
  end

  parking_report_tx_char_sel #(
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_IDX_W (SLOT_IDX_W)
  ) u_char_sel (
    .i_state  (r_state),
    .i_idx    (r_idx),
    .i_bitmap (r_active[SNAP_W-1 -: NUM_SLOTS]),
    .i_best   (r_active[2 +: SLOT_IDX_W]),
    .o_byte   (w_byte)
  );

  assign bus.tx_data  = w_byte;
  assign bus.tx_valid = (r_state != LS_IDLE);
  assign o_busy       = (r_state != LS_IDLE) || r_pend_valid;
  assign o_dropped    = r_dropped;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_parking_report_tx.sv
// Bench for parking_report_tx: table of report lines, scoreboard of expected bytes,
// and hand sequences for pending/drop, end-of-line samples, mid-line reset, CHANGE_ONLY.
module tb_parking_report_tx;
  import parking_report_tx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_report_tx_if #(.NUM_SLOTS(4), .SLOT_IDX_W(2)) if0 ();
  parking_report_tx_if #(.NUM_SLOTS(4), .SLOT_IDX_W(2)) if1 ();

  logic        busy0, dropped0, busy1, dropped1;
  line_state_t dbg0, dbg1;

  parking_report_tx #(.NUM_SLOTS(4), .SLOT_IDX_W(2), .CHANGE_ONLY(1'b0)) dut (
    .clk (clk), .reset (reset), .bus (if0),
    .o_busy (busy0), .o_dropped (dropped0), .o_dbg_state (dbg0)
  );

  parking_report_tx #(.NUM_SLOTS(4), .SLOT_IDX_W(2), .CHANGE_ONLY(1'b1)) dut_co (
    .clk (clk), .reset (reset), .bus (if1),
    .o_busy (busy1), .o_dropped (dropped1), .o_dbg_state (dbg1)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got1_q[$];
  int   acc0 = 0, drops0 = 0, acc1 = 0;
  int   rdy_mode = 0;
  logic stall_prev = 1'b0;
  logic [7:0] held;

  typedef struct {
    logic [3:0] st;
    logic [1:0] best;
    logic       door;
    logic       full;
    string      line;
    int         rdy;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Called just after a rising edge; strobe is seen by the DUT at the next edge.
  task automatic strobe0(input logic [3:0] st, input logic [1:0] best, input logic door,
                         input logic full);
    if0.sample_valid  = 1'b1;
    if0.current_state = st;
    if0.best_slot     = best;
    if0.door_open     = door;
    if0.full_light    = full;
    @(posedge clk); #1;
    if0.sample_valid  = 1'b0;
  endtask

  task automatic strobe1(input logic [3:0] st, input logic [1:0] best);
    if1.sample_valid  = 1'b1;
    if1.current_state = st;
    if1.best_slot     = best;
    if1.door_open     = 1'b0;
    if1.full_light    = 1'b0;
    @(posedge clk); #1;
    if1.sample_valid  = 1'b0;
  endtask

  // Raise a strobe so it lands on the edge that accepts the next '\n'.
  task automatic strobe0_at_eol(input string name, input logic [3:0] st,
                                input logic [1:0] best, input logic door, input logic full);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.tx_valid && if0.tx_ready && (if0.tx_data == ASC_LF)) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_eol_seen"}, 32'(found), 32'd1);
    if0.sample_valid  = 1'b1;
    if0.current_state = st;
    if0.best_slot     = best;
    if0.door_open     = door;
    if0.full_light    = full;
    @(posedge clk); #1;
    if0.sample_valid  = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy0) break;
      @(negedge clk);
    end
    check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_low"}, 32'(busy0), 32'd0);
    @(posedge clk); #1;
  endtask

  // Sink-side monitor: pops the scoreboard on every accepted byte, checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(if0.tx_valid), 32'd1);
        check("stall_data", 32'(if0.tx_data), 32'(held));
      end
      stall_prev = if0.tx_valid && !if0.tx_ready;
      held       = if0.tx_data;
      if (if0.tx_valid && if0.tx_ready) begin
        acc0++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %02h expected none", if0.tx_data);
        end else begin
          check("tx_byte", 32'(if0.tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (dropped0) drops0++;
      if (if1.tx_valid && if1.tx_ready) begin
        acc1++;
        got1_q.push_back(if1.tx_data);
      end
    end
  end

  initial begin
    if0.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       if0.tx_ready = 1'b1;
        1:       if0.tx_ready = ~if0.tx_ready;
        default: if0.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0;
    string s;
    vecs[0] = '{4'b0000, 2'd0, 1'b0, 1'b0, "0000 [4,0]\n", 0};
    vecs[1] = '{4'b1111, 2'd0, 1'b1, 1'b1, "1111 [0,0] door Full\n", 0};
    vecs[2] = '{4'b0101, 2'd1, 1'b1, 1'b0, "0101 [2,1] door\n", 1};
    vecs[3] = '{4'b1000, 2'd3, 1'b0, 1'b1, "1000 [3,3] Full\n", 2};
    vecs[4] = '{4'b0110, 2'd2, 1'b0, 1'b0, "0110 [2,2]\n", 1};
    vecs[5] = '{4'b1011, 2'd0, 1'b0, 1'b0, "1011 [1,0]\n", 2};

    reset = 1'b1;
    if0.sample_valid = 1'b0; if0.current_state = '0; if0.best_slot = '0;
    if0.door_open = 1'b0; if0.full_light = 1'b0;
    if1.sample_valid = 1'b0; if1.current_state = '0; if1.best_slot = '0;
    if1.door_open = 1'b0; if1.full_light = 1'b0; if1.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(if0.tx_valid), 32'd0);
    check("rst_tx_data", 32'(if0.tx_data), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_dropped", 32'(dropped0), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      rdy_mode = vecs[v].rdy;
      check("idle_valid", 32'(if0.tx_valid), 32'd0);
      a0 = acc0;
      push_line(vecs[v].line);
      strobe0(vecs[v].st, vecs[v].best, vecs[v].door, vecs[v].full);
      check("latency_valid", 32'(if0.tx_valid), 32'd1);
      check("first_byte", 32'(if0.tx_data), 32'(vecs[v].line[0]));
      check("busy_high", 32'(busy0), 32'd1);
      wait_idle0("vec");
      check("line_len", 32'(acc0 - a0), 32'(vecs[v].line.len()));
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // A, B, C while A is on the wire: A and C come out, B is dropped
    d0 = drops0;
    push_line("0010 [3,0]\n");
    strobe0(4'b0010, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    strobe0(4'b1100, 2'd2, 1'b1, 1'b1);
    check("b_no_drop", 32'(dropped0), 32'd0);
    strobe0(4'b0111, 2'd3, 1'b1, 1'b0);
    check("c_drop", 32'(dropped0), 32'd1);
    push_line("0111 [1,3] door\n");
    wait_idle0("abc");
    check("drop_count", 32'(drops0 - d0), 32'd1);

    // Sample on '\n' acceptance with nothing pending: starts the next line directly
    push_line("1001 [2,1]\n");
    strobe0(4'b1001, 2'd1, 1'b0, 1'b0);
    push_line("0000 [4,2] Full\n");
    strobe0_at_eol("direct", 4'b0000, 2'd2, 1'b0, 1'b1);
    check("direct_valid", 32'(if0.tx_valid), 32'd1);
    check("direct_state", 32'(dbg0), 32'(LS_BITS));
    check("direct_first", 32'(if0.tx_data), 32'h30);
    wait_idle0("direct");

    // Sample on '\n' acceptance with pending full: pending promoted, no drop
    d0 = drops0;
    push_line("1110 [1,1]\n");
    strobe0(4'b1110, 2'd1, 1'b0, 1'b0);
    push_line("0001 [3,0] door\n");
    strobe0(4'b0001, 2'd0, 1'b1, 1'b0);
    push_line("1010 [2,3]\n");
    strobe0_at_eol("promote", 4'b1010, 2'd3, 1'b0, 1'b0);
    check("promote_no_drop", 32'(dropped0), 32'd0);
    check("promote_busy", 32'(busy0), 32'd1);
    wait_idle0("promote");
    check("promote_drops", 32'(drops0 - d0), 32'd0);

    // Reset after the 5th byte aborts the line; next sample restarts cleanly
    a0 = acc0;
    push_line("1111 [0,3]\n");
    strobe0(4'b1111, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (acc0 >= a0 + 5) break;
      @(negedge clk);
    end
    check("rst5_bytes", 32'(acc0 - a0), 32'd5);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(if0.tx_valid), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    a0 = acc0;
    push_line("0100 [3,0]\n");
    strobe0(4'b0100, 2'd0, 1'b0, 1'b0);
    check("restart_first", 32'(if0.tx_data), 32'h30);
    wait_idle0("restart");
    check("restart_len", 32'(acc0 - a0), 32'd11);

    // CHANGE_ONLY: identical strobes 20 cycles apart make a single line
    got1_q.delete();
    acc1 = 0;
    strobe1(4'b0011, 2'd3);
    check("co_first_valid", 32'(if1.tx_valid), 32'd1);
    repeat (19) @(posedge clk);
    #1;
    strobe1(4'b0011, 2'd3);
    check("co_dup_valid", 32'(if1.tx_valid), 32'd0);
    check("co_dup_busy", 32'(busy1), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("co_len", 32'(acc1), 32'd11);
    s = "0011 [2,3]\n";
    for (int i = 0; i < s.len(); i++) begin
      if (i < got1_q.size()) check("co_byte", 32'(got1_q[i]), 32'(s[i]));
      else check("co_byte_missing", 32'd0, 32'(s[i]));
    end
    strobe1(4'b0011, 2'd2);
    check("co_change_valid", 32'(if1.tx_valid), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("co_len2", 32'(acc1), 32'd22);
    check("co_drop", 32'(dropped1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
